// File: rtl/ex_mem_wb_pipe_if.sv
// Signal bundle between the EX/MEM/WB bookkeeping block and the rest of the pipeline.
// The master drives the EX, ID and memory-ack inputs; the slave is the bookkeeping block.
interface ex_mem_wb_pipe_if #(
  parameter int ADDR_W = 5
);
  logic              valid_EX_i;
  logic [ADDR_W-1:0] RDaddr_EX_i;
  logic              RegWrite_EX_i;
  logic              MemRead_EX_i;
  logic              MemWrite_EX_i;
  logic              flush_i;
  logic              branch_ID_i;
  logic [ADDR_W-1:0] RS1addr_ID_i;
  logic [ADDR_W-1:0] RS2addr_ID_i;
  logic              mem_ack_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] RDaddr_EXMEM_o;
  logic              RegWrite_EXMEM_o;
  logic              MemRead_EXMEM_o;
  logic [ADDR_W-1:0] RDaddr_MEMWB_o;
  logic              RegWrite_MEMWB_o;
  logic              MemToReg_MEMWB_o;
  logic              mem_stall_o;
  logic              load_use_stall_o;
  logic              mem_err_o;

  modport master (
    output valid_EX_i, RDaddr_EX_i, RegWrite_EX_i, MemRead_EX_i, MemWrite_EX_i,
    output flush_i, branch_ID_i, RS1addr_ID_i, RS2addr_ID_i, mem_ack_i,
    input  mem_req_o, RDaddr_EXMEM_o, RegWrite_EXMEM_o, MemRead_EXMEM_o,
    input  RDaddr_MEMWB_o, RegWrite_MEMWB_o, MemToReg_MEMWB_o,
    input  mem_stall_o, load_use_stall_o, mem_err_o
  );

  modport slave (
    input  valid_EX_i, RDaddr_EX_i, RegWrite_EX_i, MemRead_EX_i, MemWrite_EX_i,
    input  flush_i, branch_ID_i, RS1addr_ID_i, RS2addr_ID_i, mem_ack_i,
    output mem_req_o, RDaddr_EXMEM_o, RegWrite_EXMEM_o, MemRead_EXMEM_o,
    output RDaddr_MEMWB_o, RegWrite_MEMWB_o, MemToReg_MEMWB_o,
    output mem_stall_o, load_use_stall_o, mem_err_o
  );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB control bookkeeping, data-memory handshake with wait timeout,
// and load-use hazard detection for branches resolved in ID.
module ex_mem_wb_pipe #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  ex_mem_wb_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              valid_exmem_q, valid_exmem_d;
  logic [ADDR_W-1:0] rd_exmem_q, rd_exmem_d;
  logic              regwrite_exmem_q, regwrite_exmem_d;
  logic              memread_exmem_q, memread_exmem_d;
  logic              memwrite_exmem_q, memwrite_exmem_d;

  logic [ADDR_W-1:0] rd_memwb_q, rd_memwb_d;
  logic              regwrite_memwb_q, regwrite_memwb_d;
  logic              memtoreg_memwb_q, memtoreg_memwb_d;

  logic memop, timeout, stall, ex_take;

  assign memop   = valid_exmem_q & (memread_exmem_q | memwrite_exmem_q);
  assign timeout = (state_q == S_WAIT) & (cnt_q == CNT_W'(MAX_WAIT - 1)) & ~bus.mem_ack_i;
  assign stall   = memop & ~bus.mem_ack_i & ~timeout;
  assign ex_take = bus.valid_EX_i & ~bus.flush_i;

  // cnt counts request cycles already spent on the current op, so the
  // abort lands exactly on the MAX_WAIT-th request cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (memop & ~bus.mem_ack_i) begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (bus.mem_ack_i | timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_exmem_d    = valid_exmem_q;
    rd_exmem_d       = rd_exmem_q;
    regwrite_exmem_d = regwrite_exmem_q;
    memread_exmem_d  = memread_exmem_q;
    memwrite_exmem_d = memwrite_exmem_q;
    rd_memwb_d       = '0;
    regwrite_memwb_d = 1'b0;
    memtoreg_memwb_d = 1'b0;
    if (!stall) begin
      valid_exmem_d    = ex_take;
      rd_exmem_d       = ex_take ? bus.RDaddr_EX_i : '0;
      regwrite_exmem_d = ex_take & bus.RegWrite_EX_i;
      memread_exmem_d  = ex_take & bus.MemRead_EX_i;
      memwrite_exmem_d = ex_take & bus.MemWrite_EX_i;
      rd_memwb_d       = rd_exmem_q;
      // An aborted access must not write back garbage.
      regwrite_memwb_d = regwrite_exmem_q & ~timeout;
      memtoreg_memwb_d = memread_exmem_q & ~timeout;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      valid_exmem_q    <= 1'b0;
      rd_exmem_q       <= '0;
      regwrite_exmem_q <= 1'b0;
      memread_exmem_q  <= 1'b0;
      memwrite_exmem_q <= 1'b0;
      rd_memwb_q       <= '0;
      regwrite_memwb_q <= 1'b0;
      memtoreg_memwb_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      valid_exmem_q    <= valid_exmem_d;
      rd_exmem_q       <= rd_exmem_d;
      regwrite_exmem_q <= regwrite_exmem_d;
      memread_exmem_q  <= memread_exmem_d;
      memwrite_exmem_q <= memwrite_exmem_d;
      rd_memwb_q       <= rd_memwb_d;
      regwrite_memwb_q <= regwrite_memwb_d;
      memtoreg_memwb_q <= memtoreg_memwb_d;
    end
  end

  assign bus.mem_req_o        = memop;
  assign bus.mem_err_o        = timeout;
  assign bus.mem_stall_o      = stall;
  assign bus.RDaddr_EXMEM_o   = rd_exmem_q;
  assign bus.RegWrite_EXMEM_o = regwrite_exmem_q;
  assign bus.MemRead_EXMEM_o  = memread_exmem_q;
  assign bus.RDaddr_MEMWB_o   = rd_memwb_q;
  assign bus.RegWrite_MEMWB_o = regwrite_memwb_q;
  assign bus.MemToReg_MEMWB_o = memtoreg_memwb_q;
  assign bus.load_use_stall_o = bus.branch_ID_i & regwrite_exmem_q & memread_exmem_q &
                                (rd_exmem_q != '0) &
                                ((rd_exmem_q == bus.RS1addr_ID_i) | (rd_exmem_q == bus.RS2addr_ID_i));
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// transaction-level model that tracks the two stage contents and request cycles spent.
module tb_ex_mem_wb_pipe;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mem_wb_pipe_if #(.ADDR_W(ADDR_W)) bus ();

  ex_mem_wb_pipe #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
  } exmem_t;

  typedef struct {
    logic [4:0] rd;
    logic       rw;
    logic       mtr;
  } memwb_t;

  exmem_t m_ex;
  memwb_t m_wb;
  int     reqn;
  int     checks = 0;
  int     errors = 0;

  logic [31:0] obs_ctl, obs_exmem, obs_memwb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic fl, input logic br, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic ack);
    bus.valid_EX_i    = v;
    bus.RDaddr_EX_i   = rd;
    bus.RegWrite_EX_i = rw;
    bus.MemRead_EX_i  = mr;
    bus.MemWrite_EX_i = mw;
    bus.flush_i       = fl;
    bus.branch_ID_i   = br;
    bus.RS1addr_ID_i  = rs1;
    bus.RS2addr_ID_i  = rs2;
    bus.mem_ack_i     = ack;
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, ack);
  endtask

  function automatic void model_reset();
    m_ex = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
    m_wb = '{rd: 5'd0, rw: 1'b0, mtr: 1'b0};
    reqn = 0;
  endfunction

  // One cycle: check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input string tag);
    logic memop, tmo, stl, lus, take;
    #4;
    memop = m_ex.valid & (m_ex.mr | m_ex.mw);
    tmo   = memop & !bus.mem_ack_i & (reqn == MAX_WAIT - 1);
    stl   = memop & !bus.mem_ack_i & !tmo;
    lus   = bus.branch_ID_i & m_ex.rw & m_ex.mr & (m_ex.rd != 5'd0) &
            ((m_ex.rd == bus.RS1addr_ID_i) | (m_ex.rd == bus.RS2addr_ID_i));
    obs_ctl   = {28'd0, bus.mem_req_o, bus.mem_stall_o, bus.load_use_stall_o, bus.mem_err_o};
    obs_exmem = {25'd0, bus.RDaddr_EXMEM_o, bus.RegWrite_EXMEM_o, bus.MemRead_EXMEM_o};
    obs_memwb = {25'd0, bus.RDaddr_MEMWB_o, bus.RegWrite_MEMWB_o, bus.MemToReg_MEMWB_o};
    chk({tag, "/ctl"},   obs_ctl,   {28'd0, memop, stl, lus, tmo});
    chk({tag, "/exmem"}, obs_exmem, {25'd0, m_ex.rd, m_ex.rw, m_ex.mr});
    chk({tag, "/memwb"}, obs_memwb, {25'd0, m_wb.rd, m_wb.rw, m_wb.mtr});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (stl) begin
      reqn++;
      m_wb = '{rd: 5'd0, rw: 1'b0, mtr: 1'b0};
    end else begin
      m_wb = '{rd: m_ex.rd, rw: m_ex.rw & !tmo, mtr: m_ex.mr & !tmo};
      take = bus.valid_EX_i & !bus.flush_i;
      m_ex = '{valid: take, rd: take ? bus.RDaddr_EX_i : 5'd0,
               rw: take & bus.RegWrite_EX_i, mr: take & bus.MemRead_EX_i,
               mw: take & bus.MemWrite_EX_i};
      reqn = 0;
    end
    #1;
  endtask

  initial begin
    int ack_pct;
    logic is_ld, is_st;
    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
    end
    model_reset();
    rst = 1'b0;
    idle(1'b0);
    step("rst");
    chk("rst_all", obs_ctl | obs_exmem | obs_memwb, 32'd0);

    // ALU flow.
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    step("alu0");
    idle(1'b0);
    step("alu1");
    chk("alu_exmem", obs_exmem, {25'd0, 5'd5, 1'b1, 1'b0});
    step("alu2");
    chk("alu_memwb", obs_memwb, {25'd0, 5'd5, 1'b1, 1'b0});

    // Load acked on the third request cycle, flush during the wait.
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    step("ld0");
    idle(1'b0);
    step("ld_r1");
    chk("ld_r1_ctl", obs_ctl, 32'b1100);
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    step("ld_r2");
    chk("ld_r2_ctl", obs_ctl, 32'b1100);
    chk("ld_r2_hold", obs_exmem, {25'd0, 5'd9, 1'b1, 1'b1});
    chk("ld_r2_bubble", obs_memwb, 32'd0);
    idle(1'b1);
    step("ld_r3");
    chk("ld_r3_ctl", obs_ctl, 32'b1000);
    idle(1'b0);
    step("ld_wb");
    chk("ld_memwb", obs_memwb, {25'd0, 5'd9, 1'b1, 1'b1});

    // Timeout with no ack.
    drive(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    step("to0");
    idle(1'b0);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      step("to_wait");
      if (k < MAX_WAIT) chk("to_stall", obs_ctl, 32'b1100);
      else              chk("to_err",   obs_ctl, 32'b1001);
    end
    step("to_after");
    chk("to_memwb", obs_memwb, {25'd0, 5'd4, 1'b0, 1'b0});
    chk("to_idle", obs_ctl, 32'd0);

    // Reset in the middle of a wait.
    drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    step("rw0");
    idle(1'b0);
    for (int k = 1; k <= 4; k++) step("rw_wait");
    rst = 1'b1;
    step("rw_rst");
    rst = 1'b0;
    step("rw_after");
    chk("rw_all", obs_ctl | obs_exmem | obs_memwb, 32'd0);

    // Load-use detection.
    drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    step("lu0");
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd7, 1'b0);
    step("lu_hit");
    chk("lu_hit", {31'd0, obs_ctl[1]}, 32'd1);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd7, 1'b1);
    step("lu_nobr");
    chk("lu_nobr", {31'd0, obs_ctl[1]}, 32'd0);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    step("lu_x0_0");
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1);
    step("lu_x0");
    chk("lu_x0", {31'd0, obs_ctl[1]}, 32'd0);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0);
    step("lu_alu");
    chk("lu_alu", {31'd0, obs_ctl[1]}, 32'd0);

    // Flush of a valid load with no stall in progress.
    drive(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    step("fl0");
    idle(1'b0);
    step("fl1");
    chk("fl_exmem", obs_exmem, 32'd0);
    chk("fl_req", {31'd0, obs_ctl[3]}, 32'd0);

    // Random traffic in three ack-rate phases; the middle one forces timeouts.
    for (int i = 0; i < 600; i++) begin
      ack_pct = (i < 200) ? 40 : (i < 400) ? 0 : 75;
      is_ld = ($urandom_range(0, 2) == 0);
      is_st = !is_ld && ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 7)), !is_st && 1'($urandom),
            is_ld, is_st, ($urandom_range(0, 7) == 0), 1'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < ack_pct));
      rst = ($urandom_range(0, 99) == 0);
      step("rnd");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
